board_controller: RTL and testbench

- Producer side of the chess display path: turns five raw push-buttons into the BOARD, CURSOR_ADDR, SELECT_ADDR and SELECT_EN signals that the VGA display block renders.
- Debounces the buttons, moves the cursor, and runs a select/move state machine that enforces turn order.
- Writes piece moves into the 64x4 board register and detects game end on king capture.
- No chess legality checking beyond side-to-move ownership.

---
 rtl/chess_defs.sv | 33 +++
 rtl/button_debouncer.sv | 46 ++++
 rtl/board_controller.sv | 177 +++++++++++++++++
 tb/tb_board_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/chess_defs.sv
// Shared definitions for the chess board controller: piece/color codes,
// FSM state encoding and the power-on board layout.
package chess_defs;

    localparam logic [2:0] PIECE_NONE   = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    localparam int BTN_UP_IDX     = 0;
    localparam int BTN_DOWN_IDX   = 1;
    localparam int BTN_LEFT_IDX   = 2;
    localparam int BTN_RIGHT_IDX  = 3;
    localparam int BTN_CENTER_IDX = 4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SELECTED  = 2'd1,
        S_MOVE      = 2'd2,
        S_GAME_OVER = 2'd3
    } state_t;

    // Square 63 is the leftmost nibble, square 0 the rightmost.
    localparam logic [255:0] BOARD_INIT =
        256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes one raw button, debounces it with a stability counter and
// emits a one-cycle pulse on each accepted press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_prev_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This increment would reach the threshold: accept the new level.
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/board_controller.sv
// Turns five push-buttons into cursor, selection and board updates for the
// chess display, enforcing side-to-move ownership and detecting king capture.
module board_controller
    import chess_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         BTN_UP,
    input  logic         BTN_DOWN,
    input  logic         BTN_LEFT,
    input  logic         BTN_RIGHT,
    input  logic         BTN_CENTER,
    output logic [255:0] BOARD,
    output logic [5:0]   CURSOR_ADDR,
    output logic [5:0]   SELECT_ADDR,
    output logic         SELECT_EN,
    output logic         TURN,
    output logic         MOVE_STROBE,
    output logic         GAME_OVER,
    output logic         WINNER
);

    logic [4:0] btn_raw;
    logic [4:0] pulse;

    assign btn_raw = {BTN_CENTER, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

    for (genvar g = 0; g < 5; g++) begin : g_db
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i  (CLK),
            .rst_i  (RESET),
            .btn_i  (btn_raw[g]),
            .pulse_o(pulse[g])
        );
    end

    state_t         state_q, state_d;
    logic [255:0]   board_q, board_d;
    logic [5:0]     cursor_q, cursor_d;
    logic [5:0]     sel_q, sel_d;
    logic [5:0]     dst_q, dst_d;
    logic           sel_en_q, sel_en_d;
    logic           turn_q, turn_d;
    logic           strobe_q, strobe_d;
    logic           go_q, go_d;
    logic           win_q, win_d;

    logic [3:0]     sq;
    logic [3:0]     src_sq;
    logic [3:0]     dst_sq;
    logic           own_sq;
    logic           center;

    assign sq     = board_q[{cursor_q, 2'b00} +: 4];
    assign src_sq = board_q[{sel_q, 2'b00} +: 4];
    assign dst_sq = board_q[{dst_q, 2'b00} +: 4];
    assign own_sq = (sq[2:0] != PIECE_NONE) && (sq[3] == turn_q);
    assign center = pulse[BTN_CENTER_IDX];

    // Opposing presses in the same cycle cancel; edges saturate.
    always_comb begin
        logic [2:0] row, col;
        row = cursor_q[5:3];
        col = cursor_q[2:0];
        if (pulse[BTN_UP_IDX] && !pulse[BTN_DOWN_IDX] && row != 3'd0)
            row = row - 3'd1;
        else if (pulse[BTN_DOWN_IDX] && !pulse[BTN_UP_IDX] && row != 3'd7)
            row = row + 3'd1;
        if (pulse[BTN_LEFT_IDX] && !pulse[BTN_RIGHT_IDX] && col != 3'd0)
            col = col - 3'd1;
        else if (pulse[BTN_RIGHT_IDX] && !pulse[BTN_LEFT_IDX] && col != 3'd7)
            col = col + 3'd1;
        cursor_d = {row, col};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (center && own_sq) state_d = S_SELECTED;
            end
            S_SELECTED: begin
                if (center) begin
                    if (cursor_q == sel_q) state_d = S_IDLE;
                    else if (!own_sq)      state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                state_d = (dst_sq[2:0] == PIECE_KING) ? S_GAME_OVER : S_IDLE;
            end
            S_GAME_OVER: state_d = S_GAME_OVER;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        board_d  = board_q;
        sel_d    = sel_q;
        sel_en_d = sel_en_q;
        dst_d    = dst_q;
        turn_d   = turn_q;
        strobe_d = 1'b0;
        go_d     = go_q;
        win_d    = win_q;
        case (state_q)
            S_IDLE: begin
                if (center && own_sq) begin
                    sel_d    = cursor_q;
                    sel_en_d = 1'b1;
                end
            end
            S_SELECTED: begin
                if (center) begin
                    if (cursor_q == sel_q) sel_en_d = 1'b0;
                    else if (own_sq)       sel_d    = cursor_q;
                    else                   dst_d    = cursor_q;
                end
            end
            S_MOVE: begin
                board_d[{dst_q, 2'b00} +: 4] = src_sq;
                board_d[{sel_q, 2'b00} +: 4] = 4'h0;
                strobe_d = 1'b1;
                sel_en_d = 1'b0;
                if (dst_sq[2:0] == PIECE_KING) begin
                    go_d  = 1'b1;
                    win_d = turn_q;
                end else begin
                    turn_d = ~turn_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            board_q  <= BOARD_INIT;
            cursor_q <= 6'd52;
            sel_q    <= 6'd0;
            dst_q    <= 6'd0;
            sel_en_q <= 1'b0;
            turn_q   <= COLOR_WHITE;
            strobe_q <= 1'b0;
            go_q     <= 1'b0;
            win_q    <= COLOR_WHITE;
        end else begin
            board_q  <= board_d;
            cursor_q <= cursor_d;
            sel_q    <= sel_d;
            dst_q    <= dst_d;
            sel_en_q <= sel_en_d;
            turn_q   <= turn_d;
            strobe_q <= strobe_d;
            go_q     <= go_d;
            win_q    <= win_d;
        end
    end

    assign BOARD       = board_q;
    assign CURSOR_ADDR = cursor_q;
    assign SELECT_ADDR = sel_q;
    assign SELECT_EN   = sel_en_q;
    assign TURN        = turn_q;
    assign MOVE_STROBE = strobe_q;
    assign GAME_OVER   = go_q;
    assign WINNER      = win_q;

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: a table of button presses with
// expected outputs, plus hand sequences for debounce timing and reset.
module tb_board_controller;

    localparam int DB = 4;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_LEFT = 1'b0;
    logic         BTN_RIGHT = 1'b0, BTN_CENTER = 1'b0;
    logic [255:0] BOARD;
    logic [5:0]   CURSOR_ADDR, SELECT_ADDR;
    logic         SELECT_EN, TURN, MOVE_STROBE, GAME_OVER, WINNER;

    board_controller #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLK(CLK), .RESET(RESET),
        .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_LEFT(BTN_LEFT),
        .BTN_RIGHT(BTN_RIGHT), .BTN_CENTER(BTN_CENTER),
        .BOARD(BOARD), .CURSOR_ADDR(CURSOR_ADDR), .SELECT_ADDR(SELECT_ADDR),
        .SELECT_EN(SELECT_EN), .TURN(TURN), .MOVE_STROBE(MOVE_STROBE),
        .GAME_OVER(GAME_OVER), .WINNER(WINNER)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int strobes = 0;

    always @(negedge CLK) if (!RESET && MOVE_STROBE) strobes++;

    // Button mask bits: 1=UP 2=DOWN 4=LEFT 8=RIGHT 16=CENTER
    typedef struct {
        logic [4:0] btn;
        logic [5:0] cur;
        logic       sel_en;
        logic [5:0] sel;
        logic       turn;
        int         strobes;
        logic       go;
        logic [5:0] sq;
        logic [3:0] sqv;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [255:0] init_board();
        logic [3:0] back_b [8];
        logic [3:0] back_w [8];
        logic [255:0] b;
        back_b = '{4'hC, 4'hA, 4'hB, 4'hD, 4'hE, 4'hB, 4'hA, 4'hC};
        back_w = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[i*4 +: 4]      = back_b[i];
            b[(8+i)*4 +: 4]  = 4'h9;
            b[(48+i)*4 +: 4] = 4'h1;
            b[(56+i)*4 +: 4] = back_w[i];
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge CLK);
        {BTN_CENTER, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP} = m;
        repeat (10) @(negedge CLK);
        {BTN_CENTER, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP} = 5'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic add(input logic [4:0] b, input logic [5:0] c, input logic e,
                       input logic [5:0] s, input logic t, input int n,
                       input logic g, input logic [5:0] q, input logic [3:0] v);
        vec_t r;
        r.btn = b; r.cur = c; r.sel_en = e; r.sel = s; r.turn = t;
        r.strobes = n; r.go = g; r.sq = q; r.sqv = v;
        vecs.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        strobes = 0;
    endtask

    localparam logic [4:0] U = 5'd1, D = 5'd2, L = 5'd4, R = 5'd8, C = 5'd16;

    initial begin
        logic [255:0] ib;
        ib = init_board();

        //   btn    cur en sel t  n go sq  val
        add(C,      52, 1, 52, 0, 0, 0, 52, 4'h1);
        add(U,      44, 1, 52, 0, 0, 0, 52, 4'h1);
        add(U,      36, 1, 52, 0, 0, 0, 36, 4'h0);
        add(C,      36, 0, 52, 1, 1, 0, 36, 4'h1);
        add(C,      36, 0, 52, 1, 1, 0, 52, 4'h0);
        add(U,      28, 0, 52, 1, 1, 0, 28, 4'h0);
        add(U,      20, 0, 52, 1, 1, 0, 20, 4'h0);
        add(U,      12, 0, 52, 1, 1, 0, 12, 4'h9);
        add(C,      12, 1, 12, 1, 1, 0, 12, 4'h9);
        add(L,      11, 1, 12, 1, 1, 0, 11, 4'h9);
        add(C,      11, 1, 11, 1, 1, 0, 11, 4'h9);
        add(R,      12, 1, 11, 1, 1, 0, 12, 4'h9);
        add(C,      12, 1, 12, 1, 1, 0, 12, 4'h9);
        add(C,      12, 0, 12, 1, 1, 0, 12, 4'h9);
        add(C,      12, 1, 12, 1, 1, 0, 12, 4'h9);
        add(D,      20, 1, 12, 1, 1, 0, 20, 4'h0);
        add(C,      20, 0, 12, 0, 2, 0, 20, 4'h9);
        add(D,      28, 0, 12, 0, 2, 0, 12, 4'h0);
        add(D,      36, 0, 12, 0, 2, 0, 36, 4'h1);
        add(C,      36, 1, 36, 0, 2, 0, 36, 4'h1);
        add(U,      28, 1, 36, 0, 2, 0, 28, 4'h0);
        add(U,      20, 1, 36, 0, 2, 0, 20, 4'h9);
        add(U,      12, 1, 36, 0, 2, 0, 12, 4'h0);
        add(U,       4, 1, 36, 0, 2, 0,  4, 4'hE);
        add(C,       4, 0, 36, 0, 3, 1,  4, 4'h1);
        add(C,       4, 0, 36, 0, 3, 1, 36, 4'h0);
        add(U,       4, 0, 36, 0, 3, 1,  4, 4'h1);
        add(L,       3, 0, 36, 0, 3, 1,  3, 4'hD);
        add(L,       2, 0, 36, 0, 3, 1,  2, 4'hB);
        add(L,       1, 0, 36, 0, 3, 1,  1, 4'hA);
        add(L,       0, 0, 36, 0, 3, 1,  0, 4'hC);
        add(L,       0, 0, 36, 0, 3, 1,  0, 4'hC);
        add(C,       0, 0, 36, 0, 3, 1,  0, 4'hC);
        add(U|D,     0, 0, 36, 0, 3, 1,  4, 4'h1);
        add(D|R,     9, 0, 36, 0, 3, 1,  9, 4'h9);
        add(L|R|D,  17, 0, 36, 0, 3, 1, 17, 4'h0);
        add(U|D|L,  16, 0, 36, 0, 3, 1, 16, 4'h0);

        // Reset state, sampled while reset is still asserted
        repeat (3) @(negedge CLK);
        chk("rst_board",   BOARD, ib);
        chk("rst_sq0",     BOARD[3:0], 4'hC);
        chk("rst_sq4",     BOARD[19:16], 4'hE);
        chk("rst_sq52",    BOARD[211:208], 4'h1);
        chk("rst_sq60",    BOARD[243:240], 4'h6);
        chk("rst_cursor",  CURSOR_ADDR, 6'd52);
        chk("rst_sel_en",  SELECT_EN, 1'b0);
        chk("rst_sel",     SELECT_ADDR, 6'd0);
        chk("rst_turn",    TURN, 1'b0);
        chk("rst_strobe",  MOVE_STROBE, 1'b0);
        chk("rst_go",      GAME_OVER, 1'b0);
        chk("rst_winner",  WINNER, 1'b0);
        RESET = 1'b0;
        strobes = 0;
        repeat (2) @(negedge CLK);

        foreach (vecs[i]) begin
            press(vecs[i].btn);
            chk($sformatf("v%0d_cursor", i), CURSOR_ADDR, vecs[i].cur);
            chk($sformatf("v%0d_sel_en", i), SELECT_EN, vecs[i].sel_en);
            chk($sformatf("v%0d_sel", i), SELECT_ADDR, vecs[i].sel);
            chk($sformatf("v%0d_turn", i), TURN, vecs[i].turn);
            chk($sformatf("v%0d_strobes", i), strobes, vecs[i].strobes);
            chk($sformatf("v%0d_game_over", i), GAME_OVER, vecs[i].go);
            chk($sformatf("v%0d_winner", i), WINNER, 1'b0);
            chk($sformatf("v%0d_sq%0d", i, vecs[i].sq),
                BOARD[{vecs[i].sq, 2'b00} +: 4], vecs[i].sqv);
        end

        // Reset out of game over restores everything
        do_reset();
        chk("go_rst_board",  BOARD, ib);
        chk("go_rst_go",     GAME_OVER, 1'b0);
        chk("go_rst_cursor", CURSOR_ADDR, 6'd52);
        chk("go_rst_turn",   TURN, 1'b0);

        // A 3-cycle glitch is shorter than the debounce window
        @(negedge CLK);
        BTN_UP = 1'b1;
        repeat (3) @(negedge CLK);
        BTN_UP = 1'b0;
        repeat (12) @(negedge CLK);
        chk("glitch_cursor", CURSOR_ADDR, 6'd52);

        // Held press: pulse after 7 edges, cursor moves on the 8th
        @(negedge CLK);
        BTN_UP = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK);
            #1;
            if (k == 7) chk("lat_before", CURSOR_ADDR, 6'd52);
            if (k == 8) chk("lat_after",  CURSOR_ADDR, 6'd44);
        end
        repeat (4) @(negedge CLK);
        BTN_UP = 1'b0;
        repeat (12) @(negedge CLK);
        chk("lat_once", CURSOR_ADDR, 6'd44);

        // Asynchronous reset in the middle of a selection
        press(D);
        press(C);
        chk("msel_en", SELECT_EN, 1'b1);
        chk("msel_addr", SELECT_ADDR, 6'd52);
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("async_sel_en", SELECT_EN, 1'b0);
        chk("async_sel",    SELECT_ADDR, 6'd0);
        chk("async_cursor", CURSOR_ADDR, 6'd52);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
